// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind valid/ready request and response channels.
// Adds LATENCY wait states and flags misaligned or out-of-range byte addresses.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// WAIT   | request captured, counting down wait states
// RESP   | response held on resp_* until resp_ready
module data_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              enter_resp;

   logic              c_we;
   logic [31:0]       c_addr;
   logic [31:0]       c_wdata;
   logic              c_err;
   logic [ADDR_W-1:0] c_idx;

   logic [31:0]       mem [DEPTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states the commit happens on the accept edge itself,
   // before the capture registers hold the request, so use the live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         c_we    = req_we;
         c_addr  = req_addr;
         c_wdata = req_wdata;
      end else begin
         c_we    = we_q;
         c_addr  = addr_q;
         c_wdata = wdata_q;
      end
      c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_W+2] != '0);
      c_idx = c_addr[ADDR_W+1:2];
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (enter_resp) begin
            err_q   <= c_err;
            rdata_q <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
         end else if (state_q == S_RESP && resp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
         end
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (!RESET && enter_resp && c_we && !c_err) mem[c_idx] <= c_wdata;
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances at LATENCY 2, 0 and 15,
// a table of single transactions plus hand-written multi-cycle sequences.
module tb_data_mem_responder;

   logic        clk;
   logic        RESET;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_we;
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic [2:0]  resp_valid;
   logic [2:0]  resp_ready;
   logic [31:0] resp_rdata [3];
   logic [2:0]  resp_err;

   int checks;
   int errors;

   data_mem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
      .clk(clk), .RESET(RESET),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   data_mem_responder #(.ADDR_W(8), .LATENCY(0)) u_l0 (
      .clk(clk), .RESET(RESET),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   data_mem_responder #(.ADDR_W(8), .LATENCY(15)) u_l15 (
      .clk(clk), .RESET(RESET),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction on instance i with resp_ready high; lat counts
   // clock cycles from the accept edge to the first cycle with resp_valid.
   task automatic txn(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
      int guard;
      @(negedge clk);
      req_we[i]     = we;
      req_addr[i]   = addr;
      req_wdata[i]  = wdata;
      req_valid[i]  = 1'b1;
      resp_ready[i] = 1'b1;
      guard = 0;
      while (!req_ready[i] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid[i] && lat < 40);
      if (!resp_valid[i]) begin
         errors++;
         $display("FAIL txn_timeout inst %0d: got no resp_valid expected resp within 40 cycles", i);
      end
      rdata = resp_rdata[i];
      err   = resp_err[i];
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lt;
   int          guard;

   initial begin
      checks = 0;
      errors = 0;
      RESET      = 1'b1;
      req_valid  = '0;
      req_we     = '0;
      resp_ready = '0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end

      vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3};
      vecs[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3};
      vecs[2] = '{1'b1, 32'h0,   32'h12345678, 32'h0,        1'b0, 3};
      vecs[3] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 3};
      vecs[4] = '{1'b1, 32'h400, 32'hCAFEF00D, 32'h0,        1'b1, 3};
      vecs[5] = '{1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0, 3};
      vecs[6] = '{1'b1, 32'h3FC, 32'h0BADF00D, 32'h0,        1'b0, 3};
      vecs[7] = '{1'b0, 32'h3FC, 32'h0,        32'h0BADF00D, 1'b0, 3};
      vecs[8] = '{1'b1, 32'h20,  32'h11112222, 32'h0,        1'b0, 3};
      vecs[9] = '{1'b0, 32'h20,  32'h0,        32'h11112222, 1'b0, 3};

      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_req_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
         chk($sformatf("reset_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
      end
      chk("reset_rdata", resp_rdata[0], 32'd0);
      chk("reset_err", 32'(resp_err[0]), 32'd0);

      for (int v = 0; v < 10; v++) begin
         txn(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, rd, er, lt);
         chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
         chk($sformatf("vec%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
         chk($sformatf("vec%0d_lat", v), 32'(lt), 32'(vecs[v].exp_lat));
      end

      // Stall in RESP with resp_ready low while the request bus churns.
      @(negedge clk);
      req_we[0] = 1'b0; req_addr[0] = 32'h10; req_valid[0] = 1'b1; resp_ready[0] = 1'b0;
      @(posedge clk);
      #1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!resp_valid[0] && guard < 40);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_valid", c), 32'(resp_valid[0]), 32'd1);
         chk($sformatf("stall%0d_rdata", c), resp_rdata[0], 32'hDEADBEEF);
         chk($sformatf("stall%0d_err", c), 32'(resp_err[0]), 32'd0);
         chk($sformatf("stall%0d_req_ready", c), 32'(req_ready[0]), 32'd0);
         req_addr[0]  = 32'h13 + 32'(c);
         req_wdata[0] = 32'hF0F0_0000 + 32'(c);
         req_we[0]    = c[0];
         @(negedge clk);
      end
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b0;
      @(negedge clk);
      chk("stall_exit_req_ready", 32'(req_ready[0]), 32'd1);
      chk("stall_exit_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("stall_exit_rdata", resp_rdata[0], 32'd0);

      // Reset during WAIT must abort the pending store.
      req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAA5555; req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      RESET = 1'b1;
      @(posedge clk);
      #1;
      RESET = 1'b0;
      @(negedge clk);
      chk("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
      chk("rst_wait_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("rst_wait_rdata", resp_rdata[0], 32'd0);
      txn(0, 1'b0, 32'h20, 32'h0, rd, er, lt);
      chk("rst_wait_old_data", rd, 32'h11112222);
      chk("rst_wait_old_err", 32'(er), 32'd0);

      // Zero wait states: back-to-back loads with req_valid held high.
      txn(1, 1'b1, 32'h4, 32'h55, rd, er, lt);
      chk("l0_store_lat", 32'(lt), 32'd1);
      txn(1, 1'b1, 32'h8, 32'h66, rd, er, lt);
      chk("l0_store2_lat", 32'(lt), 32'd1);
      @(negedge clk);
      req_we[1] = 1'b0; req_addr[1] = 32'h4; req_valid[1] = 1'b1; resp_ready[1] = 1'b1;
      chk("b2b_n0_ready", 32'(req_ready[1]), 32'd1);
      chk("b2b_n0_valid", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
      chk("b2b_n1_ready", 32'(req_ready[1]), 32'd0);
      chk("b2b_n1_valid", 32'(resp_valid[1]), 32'd1);
      chk("b2b_n1_rdata", resp_rdata[1], 32'h55);
      req_addr[1] = 32'h8;
      @(negedge clk);
      chk("b2b_n2_ready", 32'(req_ready[1]), 32'd1);
      chk("b2b_n2_valid", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
      chk("b2b_n3_ready", 32'(req_ready[1]), 32'd0);
      chk("b2b_n3_valid", 32'(resp_valid[1]), 32'd1);
      chk("b2b_n3_rdata", resp_rdata[1], 32'h66);
      req_valid[1] = 1'b0;

      // Fifteen wait states on the top word index.
      txn(2, 1'b1, 32'h3FC, 32'h0F0F0F0F, rd, er, lt);
      chk("l15_store_lat", 32'(lt), 32'd16);
      chk("l15_store_err", 32'(er), 32'd0);
      txn(2, 1'b0, 32'h3FC, 32'h0, rd, er, lt);
      chk("l15_load_lat", 32'(lt), 32'd16);
      chk("l15_load_rdata", rd, 32'h0F0F0F0F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
